// File: rtl/motor_cmd_ramp.sv
// Slew-limited duty/direction generator for one H-bridge channel.
// Sign reversals ramp to zero, hold a dead time, then flip the direction bit.
module motor_cmd_ramp #(
  parameter int nbits       = 8,
  parameter int step        = 1,
  parameter int ramp_div    = 48000,
  parameter int dead_cycles = 4800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [nbits:0]   cmd,
  input  logic             cmd_valid,
  output logic [nbits-1:0] duty,
  output logic             dir,
  output logic             at_target
);

  // state   | meaning
  // ST_RUN  | duty slews toward target (or toward 0 if direction must change)
  // ST_DEAD | duty held at 0 for dead_cycles clocks before dir flips

  localparam int pw = (ramp_div > 1) ? $clog2(ramp_div) : 1;
  localparam int dw = (dead_cycles > 1) ? $clog2(dead_cycles) : 1;
  localparam logic [pw-1:0]    presc_last = pw'(ramp_div - 1);
  localparam logic [pw-1:0]    presc_one  = pw'(1);
  localparam logic [dw-1:0]    dead_load  = dw'(dead_cycles - 1);
  localparam logic [dw-1:0]    dead_one   = dw'(1);
  localparam logic [nbits:0]   step_w     = (nbits+1)'(step);
  localparam logic [nbits:0]   one_w      = (nbits+1)'(1);
  localparam logic [nbits:0]   mag_max    = {1'b0, {nbits{1'b1}}};

  typedef enum logic {ST_RUN, ST_DEAD} state_t;

  state_t           state, state_next;
  logic [pw-1:0]    presc;
  logic [dw-1:0]    dead_cnt, dead_next;
  logic [nbits-1:0] duty_next;
  logic             dir_next;
  logic             at_next;
  logic [nbits-1:0] target_mag;
  logic             target_dir;
  logic             tick;
  logic [nbits:0]   cmd_abs;
  logic [nbits-1:0] cmd_mag;
  logic [nbits:0]   duty_w, tgt_w;
  logic [nbits-1:0] step_n;

  // Only -2**nbits has a magnitude that does not fit in nbits.
  always_comb begin
    cmd_abs = cmd[nbits] ? (~cmd + one_w) : cmd;
    cmd_mag = cmd_abs[nbits] ? mag_max[nbits-1:0] : cmd_abs[nbits-1:0];
  end

  assign tick   = en && (presc == presc_last);
  assign duty_w = {1'b0, duty};
  assign tgt_w  = {1'b0, target_mag};
  assign step_n = step_w[nbits-1:0];

  always_ff @(posedge clk) begin
    if (rst || !en)  presc <= '0;
    else if (tick)   presc <= '0;
    else             presc <= presc + presc_one;
  end

  always_comb begin
    state_next = state;
    duty_next  = duty;
    dir_next   = dir;
    dead_next  = dead_cnt;
    case (state)
      ST_RUN: begin
        if (tick) begin
          if (target_mag != '0 && target_dir != dir) begin
            if (duty == '0) begin
              state_next = ST_DEAD;
              dead_next  = dead_load;
            end else if (duty_w > step_w) begin
              duty_next = duty - step_n;
            end else begin
              duty_next = '0;
            end
          end else if (duty_w < tgt_w) begin
            duty_next = (tgt_w - duty_w > step_w) ? duty + step_n : target_mag;
          end else if (duty_w > tgt_w) begin
            duty_next = (duty_w - tgt_w > step_w) ? duty - step_n : target_mag;
          end
        end
      end
      ST_DEAD: begin
        duty_next = '0;
        if (dead_cnt == '0) begin
          state_next = ST_RUN;
          if (target_mag != '0) dir_next = target_dir;
        end else begin
          dead_next = dead_cnt - dead_one;
        end
      end
      default: state_next = ST_RUN;
    endcase
    if (!en) begin
      state_next = ST_RUN;
      duty_next  = '0;
      dead_next  = '0;
      dir_next   = dir;
    end
    // Compared against the target held before this edge, so a fresh command
    // shows up on at_target one edge after it is latched.
    at_next = (state_next == ST_RUN) && (duty_next == target_mag) &&
              ((dir_next == target_dir) || (target_mag == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      duty       <= '0;
      dir        <= 1'b0;
      at_target  <= 1'b1;
      dead_cnt   <= '0;
      target_mag <= '0;
      target_dir <= 1'b0;
    end else begin
      state     <= state_next;
      duty      <= duty_next;
      dir       <= dir_next;
      at_target <= at_next;
      dead_cnt  <= dead_next;
      if (!en) begin
        target_mag <= '0;
      end else if (cmd_valid) begin
        target_mag <= cmd_mag;
        target_dir <= cmd[nbits];
      end
    end
  end

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Directed bench for motor_cmd_ramp with nbits=8, step=4, ramp_div=2, dead_cycles=3.
module tb_motor_cmd_ramp;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [8:0] cmd;
  logic       cmd_valid;
  logic [7:0] duty;
  logic       dir;
  logic       at_target;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  motor_cmd_ramp #(.nbits(8), .step(4), .ramp_div(2), .dead_cycles(3)) dut (
    .clk(clk), .rst(rst), .en(en), .cmd(cmd), .cmd_valid(cmd_valid),
    .duty(duty), .dir(dir), .at_target(at_target)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [8:0] v);
    cmd = v;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for duty to change, then checks the new value.
  task automatic wait_change(input string tag, input int exp, input int budget, output int cycles);
    logic [7:0] prev;
    prev = duty;
    cycles = 0;
    while (duty == prev && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    chk(tag, duty, exp);
  endtask

  initial begin
    int cyc, bad, prev;
    rst = 1'b1; en = 1'b1; cmd = '0; cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset / idle
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (duty != 0 || dir != 0 || at_target != 1) bad++;
    end
    chk("idle_duty", duty, 0);
    chk("idle_dir", dir, 0);
    chk("idle_at_target", at_target, 1);
    chk("idle_stable", bad, 0);

    // ramp to +10
    strobe(9'd10);
    wait_change("up_4", 4, 4, cyc);
    chk("up_4_at_target", at_target, 0);
    wait_change("up_8", 8, 4, cyc);
    chk("up_8_hold", cyc, 2);
    chk("up_8_at_target", at_target, 0);
    wait_change("up_10", 10, 4, cyc);
    chk("up_10_hold", cyc, 2);
    chk("up_10_at_target", at_target, 1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (duty != 10) bad++;
    end
    chk("up_10_no_overshoot", bad, 0);

    // reversal from 8 forward to -8
    strobe(9'd8);
    wait_change("to_8", 8, 4, cyc);
    chk("to_8_dir", dir, 0);
    strobe(9'h1F8);
    wait_change("rev_down_4", 4, 4, cyc);
    wait_change("rev_down_0", 0, 4, cyc);
    chk("rev_down_0_hold", cyc, 2);
    cyc = 0; bad = 0;
    while (dir == 1'b0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (duty != 0) bad++;
      if (dir == 1'b0 && at_target != 0) bad++;
    end
    chk("rev_zero_to_flip", cyc, 5);
    chk("rev_dead_duty0", bad, 0);
    chk("rev_dir", dir, 1);
    wait_change("rev_up_4", 4, 4, cyc);
    chk("rev_up_4_after_flip", cyc, 1);
    wait_change("rev_up_8", 8, 4, cyc);
    chk("rev_up_8_hold", cyc, 2);
    chk("rev_at_target", at_target, 1);

    // saturated -256 -> 255
    strobe(9'h100);
    cyc = 0; bad = 0; prev = duty;
    while (duty != 255 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (duty < prev) bad++;
      prev = duty;
    end
    chk("sat_reach_255", duty, 255);
    chk("sat_monotonic", bad, 0);
    chk("sat_dir", dir, 1);
    chk("sat_at_target", at_target, 1);
    repeat (4) @(negedge clk);
    chk("sat_hold_255", duty, 255);

    // cmd=0: ramp down, dir held, no dead time
    strobe(9'd0);
    cyc = 0; bad = 0; prev = duty;
    while (duty != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (duty > prev || dir != 1) bad++;
      prev = duty;
    end
    chk("zero_reach_0", duty, 0);
    chk("zero_monotonic_dir", bad, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (at_target != 1 || dir != 1 || duty != 0) bad++;
    end
    chk("zero_no_dead", bad, 0);

    // en dropped mid-ramp at duty=8
    strobe(9'd20);
    cyc = 0;
    while (duty != 8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("en_reach_8", duty, 8);
    chk("en_dir_fwd", dir, 0);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_duty", duty, 0);
    chk("en_off_dir", dir, 0);
    en = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (duty != 0) bad++;
    end
    chk("en_target_cleared", bad, 0);
    chk("en_at_target", at_target, 1);

    // reset during dead time
    strobe(9'h1FC);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("rst_dir", dir, 0);
    chk("rst_at_target", at_target, 1);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dir != 0 || duty != 0 || at_target != 1) bad++;
    end
    chk("rst_no_dead_completion", bad, 0);
    strobe(9'd4);
    wait_change("rst_up_4", 4, 3, cyc);
    chk("rst_up_4_at_target", at_target, 1);
    chk("rst_up_4_dir", dir, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
